// File: rtl/dlx_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dlx_mem_arbiter
// Purpose  : Shares one single-ported SRAM between the DLX instruction-fetch
//            port and the data port. Each access is sequenced as
//            IDLE -> ACCESS (WAIT_STATES+1 cycles) -> RESP (ack cycle).
//            Simultaneous requests are resolved by fixed priority (data
//            wins) or round-robin, selected by ARB_MODE.
// Ports    : clk, rst            clock (rising edge), synchronous reset (high)
//            i_req/i_addr        instruction read request and address
//            i_rdata/i_ack       instruction read data, one-cycle completion
//            d_req/d_we/d_addr   data request, write enable, address
//            d_wdata             data write data
//            d_rdata/d_ack       data read data, one-cycle completion
//            m_addr/m_wdata      SRAM address and write data
//            m_we/m_re           SRAM write / read enables (never both high)
//            m_rdata             SRAM read data
//            busy                high whenever an access is in progress
// Revision : 1.0  initial release
// ============================================================================
module dlx_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_we,
  output logic              m_re,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] c_WAIT = 4'(WAIT_STATES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                win_data_q, win_data_d;    // current access belongs to data port
  logic                last_data_q, last_data_d;  // last grant went to data port
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic                m_we_q, m_we_d;
  logic                m_re_q, m_re_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;
  logic                w_grant_data;

  // Data port wins when it is the only requester; under contention it wins
  // in fixed-priority mode, or in round-robin mode when instruction was
  // granted last.
  always_comb begin
    w_grant_data = d_req && (!i_req || (ARB_MODE == 0) || !last_data_q);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_data_d  = win_data_q;
    last_data_d = last_data_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_we_d      = m_we_q;
    m_re_d      = m_re_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          win_data_d  = w_grant_data;
          last_data_d = w_grant_data;
          m_addr_d    = w_grant_data ? d_addr : i_addr;
          if (w_grant_data) begin
            m_wdata_d = d_wdata;
          end
          // Instruction fetches are always reads.
          m_we_d  = w_grant_data && d_we;
          m_re_d  = !(w_grant_data && d_we);
          cnt_d   = c_WAIT;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Last memory cycle: capture read data so it is valid with the ack.
          if (m_re_q) begin
            if (win_data_q) begin
              d_rdata_d = m_rdata;
            end else begin
              i_rdata_d = m_rdata;
            end
          end
          i_ack_d = !win_data_q;
          d_ack_d = win_data_q;
          m_we_d  = 1'b0;
          m_re_d  = 1'b0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      win_data_q  <= 1'b0;
      last_data_q <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_we_q      <= 1'b0;
      m_re_q      <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_data_q  <= win_data_d;
      last_data_q <= last_data_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_we_q      <= m_we_d;
      m_re_q      <= m_re_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_we    = m_we_q;
  assign m_re    = m_re_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire
